// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day counter: set-mode encodings,
// field limits and a small decimal-to-BCD helper.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_e;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HR24_MAX = 23;
    localparam int HR12_MIN = 1;
    localparam int HR12_MAX = 12;

    // Converts a value in 0..99 into two packed BCD digits {tens, units}.
    function automatic logic [7:0] to_bcd(input int value);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(value / 10);
        u = 4'(value % 10);
        return {t, u};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX_VAL back to RELOAD_VAL.
// carry_out flags the increment that causes the wrap, so a chain of
// these counters ripples within a single clock edge.
module bcd_mod_counter #(
    parameter int MAX_VAL    = 59,
    parameter int RELOAD_VAL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clear,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       carry_out
);

    localparam logic [3:0] MAX_T    = 4'(MAX_VAL / 10);
    localparam logic [3:0] MAX_U    = 4'(MAX_VAL % 10);
    localparam logic [3:0] RELOAD_T = 4'(RELOAD_VAL / 10);
    localparam logic [3:0] RELOAD_U = 4'(RELOAD_VAL % 10);

    logic at_max;

    assign at_max    = (tens == MAX_T) && (units == MAX_U);
    assign carry_out = inc && at_max;

    // Digit registers: reset/clear to 00, otherwise BCD increment with wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tens  <= 4'd0;
            units <= 4'd0;
        end else if (clear) begin
            tens  <= 4'd0;
            units <= 4'd0;
        end else if (inc) begin
            if (at_max) begin
                tens  <= RELOAD_T;
                units <= RELOAD_U;
            end else if (units == 4'd9) begin
                tens  <= tens + 4'd1;
                units <= 4'd0;
            end else begin
                units <= units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/time_of_day_counter.sv
// Time-of-day core: BCD seconds/minutes/hours driven by a 1 Hz enable
// strobe, with a three-state set mode (RUN / SET_HR / SET_MIN) stepped by
// btn_mode. Handshake note: tick_1hz, btn_mode and btn_inc are one-cycle
// pulses sampled on the clock edge when enable=1; there is no back-pressure,
// and every pulse not taken in that cycle is dropped.
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter bit H24 = 1'b1
) (
    input  logic       clock_50MHZ,
    input  logic       reset,
    input  logic       enable,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] hr_t,
    output logic [3:0] hr_u,
    output logic       pm,
    output logic [1:0] mode,
    output logic       day_wrap
);

    mode_e mode_q;
    mode_e mode_d;

    logic mode_adv;
    logic run_tick;
    logic sec_clear;
    logic sec_carry;
    logic min_inc;
    logic min_carry;
    logic hr_run_inc;
    logic hr_set_inc;
    logic hr_inc;
    logic hr_wrap;

    // btn_mode beats both btn_inc and tick_1hz in the same cycle.
    assign mode_adv   = enable && btn_mode;
    assign run_tick   = enable && tick_1hz && !btn_mode && (mode_q == MODE_RUN);
    assign sec_clear  = mode_adv && (mode_q == MODE_RUN);
    assign min_inc    = (run_tick && sec_carry) ||
                        (enable && btn_inc && !btn_mode && (mode_q == MODE_SET_MIN));
    assign hr_run_inc = run_tick && min_carry;
    assign hr_set_inc = enable && btn_inc && !btn_mode && (mode_q == MODE_SET_HR);
    assign hr_inc     = hr_run_inc || hr_set_inc;
    assign mode       = mode_q;

    // Set-mode state register.
    always_ff @(posedge clock_50MHZ) begin
        if (!reset) begin
            mode_q <= MODE_RUN;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Next set-mode state: only btn_mode moves the FSM around its ring.
    always_comb begin
        mode_d = mode_q;
        if (mode_adv) begin
            case (mode_q)
                MODE_RUN:    mode_d = MODE_SET_HR;
                MODE_SET_HR: mode_d = MODE_SET_MIN;
                default:     mode_d = MODE_RUN;
            endcase
        end
    end

    bcd_mod_counter #(.MAX_VAL(SEC_MAX), .RELOAD_VAL(0)) u_sec (
        .clk       (clock_50MHZ),
        .reset     (reset),
        .inc       (run_tick),
        .clear     (sec_clear),
        .tens      (sec_t),
        .units     (sec_u),
        .carry_out (sec_carry)
    );

    // In set mode min_carry can fire on a 59->00 wrap, but hr_run_inc
    // only listens to it while running, so set adjustments never carry.
    bcd_mod_counter #(.MAX_VAL(MIN_MAX), .RELOAD_VAL(0)) u_min (
        .clk       (clock_50MHZ),
        .reset     (reset),
        .inc       (min_inc),
        .clear     (1'b0),
        .tens      (min_t),
        .units     (min_u),
        .carry_out (min_carry)
    );

    generate
        if (H24) begin : g_hr24
            logic hr_carry;

            bcd_mod_counter #(.MAX_VAL(HR24_MAX), .RELOAD_VAL(0)) u_hr (
                .clk       (clock_50MHZ),
                .reset     (reset),
                .inc       (hr_inc),
                .clear     (1'b0),
                .tens      (hr_t),
                .units     (hr_u),
                .carry_out (hr_carry)
            );

            assign pm      = 1'b0;
            assign hr_wrap = hr_run_inc && hr_carry;
        end else begin : g_hr12
            localparam logic [7:0] HR_11 = to_bcd(HR12_MAX - 1);
            localparam logic [7:0] HR_12 = to_bcd(HR12_MAX);
            localparam logic [7:0] HR_01 = to_bcd(HR12_MIN);

            logic [7:0] hr_q;
            logic       pm_q;

            assign hr_t    = hr_q[7:4];
            assign hr_u    = hr_q[3:0];
            assign pm      = pm_q;
            assign hr_wrap = hr_run_inc && (hr_q == HR_11) && pm_q;

            // 12-hour sequence 12,01..11 with the AM/PM flip on 11 -> 12.
            always_ff @(posedge clock_50MHZ) begin
                if (!reset) begin
                    hr_q <= HR_12;
                    pm_q <= 1'b0;
                end else if (hr_inc) begin
                    if (hr_q == HR_11) begin
                        hr_q <= HR_12;
                        pm_q <= !pm_q;
                    end else if (hr_q == HR_12) begin
                        hr_q <= HR_01;
                    end else if (hr_q[3:0] == 4'd9) begin
                        hr_q <= {hr_q[7:4] + 4'd1, 4'd0};
                    end else begin
                        hr_q <= {hr_q[7:4], hr_q[3:0] + 4'd1};
                    end
                end
            end
        end
    endgenerate

    // Registered day-start pulse; low whenever enable is low.
    always_ff @(posedge clock_50MHZ) begin
        if (!reset) begin
            day_wrap <= 1'b0;
        end else begin
            day_wrap <= hr_wrap;
        end
    end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: one 24-hour and one 12-hour instance see
// the same stimulus. An integer time model predicts both every cycle, and
// a table of preset/run scenarios plus corner sequences check fixed values.
module tb_time_of_day_counter;

    localparam int W = 56;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;
    logic enable = 1'b1;
    logic tick_1hz = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_inc = 1'b0;

    logic [3:0] a_sec_t, a_sec_u, a_min_t, a_min_u, a_hr_t, a_hr_u;
    logic       a_pm, a_dw;
    logic [1:0] a_mode;
    logic [3:0] b_sec_t, b_sec_u, b_min_t, b_min_u, b_hr_t, b_hr_u;
    logic       b_pm, b_dw;
    logic [1:0] b_mode;

    time_of_day_counter #(.H24(1'b1)) u_dut24 (
        .clock_50MHZ(clk), .reset(reset), .enable(enable), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_t(a_sec_t), .sec_u(a_sec_u), .min_t(a_min_t), .min_u(a_min_u),
        .hr_t(a_hr_t), .hr_u(a_hr_u), .pm(a_pm), .mode(a_mode), .day_wrap(a_dw)
    );

    time_of_day_counter #(.H24(1'b0)) u_dut12 (
        .clock_50MHZ(clk), .reset(reset), .enable(enable), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_t(b_sec_t), .sec_u(b_sec_u), .min_t(b_min_t), .min_u(b_min_u),
        .hr_t(b_hr_t), .hr_u(b_hr_u), .pm(b_pm), .mode(b_mode), .day_wrap(b_dw)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference model state.
    int m_mode = 0, m_sec = 0, m_min = 0, m_hr24 = 0, m_hr12 = 12;
    bit m_pm = 0, m_dw24 = 0, m_dw12 = 0;
    bit cur_en = 1, cur_rs = 1;

    typedef struct {
        int hr_incs;
        int min_incs;
        int n_ticks;
        int e_hr24;
        int e_hr12;
        int e_min;
        int e_sec;
        bit e_pm;
    } vec_t;

    vec_t vec[6];

    function automatic logic [27:0] pack_exp(int s, int m, int h, bit p, int md, bit dw);
        return {4'(s / 10), 4'(s % 10), 4'(m / 10), 4'(m % 10),
                4'(h / 10), 4'(h % 10), p, 2'(md), dw};
    endfunction

    function automatic bit bcd_ok(logic [27:0] v);
        return (v[27:24] <= 4'd5) && (v[23:20] <= 4'd9) && (v[19:16] <= 4'd5) &&
               (v[15:12] <= 4'd9) && (v[11:8] <= 4'd2) && (v[7:4] <= 4'd9);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic hr12_inc();
        if (m_hr12 == 11) begin
            m_hr12 = 12;
            m_pm = !m_pm;
        end else if (m_hr12 == 12) begin
            m_hr12 = 1;
        end else begin
            m_hr12++;
        end
    endtask

    task automatic model_step(bit rs, bit t, bit bm, bit bi, bit en);
        if (!rs) begin
            m_mode = 0; m_sec = 0; m_min = 0; m_hr24 = 0; m_hr12 = 12;
            m_pm = 0; m_dw24 = 0; m_dw12 = 0;
        end else if (!en) begin
            m_dw24 = 0; m_dw12 = 0;
        end else begin
            m_dw24 = 0; m_dw12 = 0;
            if (bm) begin
                if (m_mode == 0) m_sec = 0;
                m_mode = (m_mode == 2) ? 0 : m_mode + 1;
            end else if (m_mode == 0) begin
                if (t) begin
                    if (m_sec == 59) begin
                        m_sec = 0;
                        if (m_min == 59) begin
                            m_min = 0;
                            if (m_hr24 == 23) begin
                                m_hr24 = 0;
                                m_dw24 = 1;
                            end else begin
                                m_hr24++;
                            end
                            if (m_hr12 == 11 && m_pm) m_dw12 = 1;
                            hr12_inc();
                        end else begin
                            m_min++;
                        end
                    end else begin
                        m_sec++;
                    end
                end
            end else if (m_mode == 1) begin
                if (bi) begin
                    m_hr24 = (m_hr24 + 1) % 24;
                    hr12_inc();
                end
            end else if (bi) begin
                m_min = (m_min + 1) % 60;
            end
        end
    endtask

    // One clock: drive inputs, predict, then compare the popped expectation.
    task automatic cycle(input bit t, input bit bm, input bit bi);
        logic [W-1:0] e;
        logic [27:0]  g24;
        logic [27:0]  g12;
        tick_1hz = t;
        btn_mode = bm;
        btn_inc  = bi;
        enable   = cur_en;
        reset    = cur_rs;
        model_step(cur_rs, t, bm, bi, cur_en);
        exp_q.push_back({pack_exp(m_sec, m_min, m_hr24, 1'b0, m_mode, m_dw24),
                         pack_exp(m_sec, m_min, m_hr12, m_pm, m_mode, m_dw12)});
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        g24 = {a_sec_t, a_sec_u, a_min_t, a_min_u, a_hr_t, a_hr_u, a_pm, a_mode, a_dw};
        g12 = {b_sec_t, b_sec_u, b_min_t, b_min_u, b_hr_t, b_hr_u, b_pm, b_mode, b_dw};
        check("sb24", 32'(g24), 32'(e[55:28]));
        check("sb12", 32'(g12), 32'(e[27:0]));
        check("bcd24", 32'(bcd_ok(g24)), 32'd1);
        check("bcd12", 32'(bcd_ok(g12)), 32'd1);
    endtask

    task automatic do_reset();
        cur_rs = 0;
        cycle(0, 0, 0);
        cur_rs = 1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1);
    endtask

    task automatic preset(input int h, input int m, input int n);
        do_reset();
        cycle(0, 1, 0);
        press_inc(h);
        cycle(0, 1, 0);
        press_inc(m);
        cycle(0, 1, 0);
        ticks(n);
    endtask

    initial begin
        vec[0] = '{23, 59, 58, 23, 11, 59, 58, 1'b1};
        vec[1] = '{0,  0,  60, 0,  12, 1,  0,  1'b0};
        vec[2] = '{11, 59, 60, 12, 12, 0,  0,  1'b1};
        vec[3] = '{23, 59, 60, 0,  12, 0,  0,  1'b0};
        vec[4] = '{5,  7, 125, 5,  5,  9,  5,  1'b0};
        vec[5] = '{12, 0,  0,  12, 12, 0,  0,  1'b1};

        // Reset state.
        do_reset();
        check("reset24", {a_hr_t, a_hr_u, a_min_t, a_min_u, a_sec_t, a_sec_u, 2'b00, a_mode, a_dw, a_pm},
              {24'h000000, 2'b00, 2'd0, 1'b0, 1'b0});
        check("reset12", {b_hr_t, b_hr_u, b_min_t, b_min_u, b_sec_t, b_sec_u, 2'b00, b_mode, b_dw, b_pm},
              {24'h120000, 2'b00, 2'd0, 1'b0, 1'b0});

        // Table of preset-and-run scenarios.
        for (int i = 0; i < 6; i++) begin
            preset(vec[i].hr_incs, vec[i].min_incs, vec[i].n_ticks);
            check($sformatf("vec24[%0d]", i),
                  {a_hr_t, a_hr_u, a_min_t, a_min_u, a_sec_t, a_sec_u, 2'b00, a_mode},
                  {4'(vec[i].e_hr24 / 10), 4'(vec[i].e_hr24 % 10), 4'(vec[i].e_min / 10),
                   4'(vec[i].e_min % 10), 4'(vec[i].e_sec / 10), 4'(vec[i].e_sec % 10), 4'd0});
            check($sformatf("vec12[%0d]", i),
                  {a_pm, b_pm, 2'b00, b_hr_t, b_hr_u, b_min_t, b_min_u, b_sec_t, b_sec_u},
                  {1'b0, vec[i].e_pm, 2'b00, 4'(vec[i].e_hr12 / 10), 4'(vec[i].e_hr12 % 10),
                   4'(vec[i].e_min / 10), 4'(vec[i].e_min % 10),
                   4'(vec[i].e_sec / 10), 4'(vec[i].e_sec % 10)});
        end

        // Seconds-to-minutes carry on the 60th tick.
        do_reset();
        ticks(59);
        check("carry_pre", {a_min_u, a_sec_t, a_sec_u}, {4'd0, 4'd5, 4'd9});
        ticks(1);
        check("carry_min", {a_min_u, a_sec_t, a_sec_u}, {4'd1, 4'd0, 4'd0});

        // Day wrap: high for exactly one cycle in both variants.
        preset(23, 59, 58);
        ticks(1);
        check("wrap_pre", {a_hr_t, a_hr_u, a_sec_t, a_sec_u, a_dw, b_dw}, {16'h2359, 2'b00});
        ticks(1);
        check("wrap_hit", {a_hr_t, a_hr_u, a_min_t, a_min_u, b_hr_t, b_hr_u, b_pm, a_dw, b_dw},
              {16'h0000, 8'h12, 1'b0, 2'b11});
        cycle(0, 0, 0);
        check("wrap_one", {a_dw, b_dw}, 2'b00);

        // Set mode walk-through from 10:20:35.
        preset(10, 20, 35);
        check("set_start", {a_hr_t, a_hr_u, a_min_t, a_min_u, a_sec_t, a_sec_u}, 24'h102035);
        cycle(0, 1, 0);
        check("set_hr_entry", {a_mode, 2'b00, a_sec_t, a_sec_u}, {2'd1, 2'b00, 8'h00});
        for (int i = 0; i < 14; i++) cycle(i[0], 0, 1);
        ticks(3);
        check("set_hr_wrap", {a_hr_t, a_hr_u, b_hr_t, b_hr_u, a_sec_t, a_sec_u, 3'b000, b_pm},
              {8'h00, 8'h12, 8'h00, 4'h0});
        cycle(0, 1, 0);
        press_inc(45);
        check("set_min_wrap", {a_mode, 2'b00, a_min_t, a_min_u, a_hr_t, a_hr_u}, {2'd2, 2'b00, 16'h0500});
        cycle(0, 1, 0);
        ticks(1);
        check("resume", {a_mode, 2'b00, a_hr_t, a_hr_u, a_min_t, a_min_u, a_sec_t, a_sec_u},
              {2'd0, 2'b00, 24'h000501});

        // Same-cycle priority.
        cycle(1, 1, 0);
        check("prio_tick", {a_mode, 2'b00, a_sec_t, a_sec_u, a_min_t, a_min_u}, {2'd1, 2'b00, 16'h0005});
        cycle(0, 1, 1);
        check("prio_inc", {a_mode, 2'b00, a_hr_t, a_hr_u, a_min_t, a_min_u}, {2'd2, 2'b00, 16'h0005});

        // Frozen while disabled, with random strobes and buttons.
        cur_en = 0;
        for (int i = 0; i < 1000; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        cur_en = 1;
        check("freeze", {a_mode, 2'b00, a_hr_t, a_hr_u, a_min_t, a_min_u, a_sec_t, a_sec_u},
              {2'd2, 2'b00, 24'h000500});

        // Reset in SET_MIN with every other input active.
        cur_rs = 0;
        cycle(1, 1, 1);
        cur_rs = 1;
        check("reset_mid", {a_mode, b_mode, a_hr_t, a_hr_u, b_hr_t, b_hr_u, a_min_t, a_min_u, a_sec_t, a_sec_u},
              {2'd0, 2'd0, 8'h00, 8'h12, 16'h0000});

        // btn_inc in RUN is ignored; then a random run against the model.
        press_inc(3);
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0),
                  ($urandom_range(0, 3) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Timekeeping core of the digital clock: counts seconds, minutes and hours in BCD from a 1 Hz strobe supplied by the divider chain.
- Provides a user set mode (hour and minute adjust) driven by debounced button pulses.
- Feeds the 7-segment display path and any alarm logic.
- All state lives in the clock_50MHZ domain; the 1 Hz input is a single-cycle enable strobe, never used as a clock.

Parameters:
- H24, 1, 1 = 24-hour count (00..23); 0 = 12-hour count (12,01..11) with AM/PM flag.

Ports:
- clock_50MHZ  input  1  system clock
- reset  input  1  synchronous, active-low reset
- enable  input  1  1 = normal operation; 0 = freeze all state and ignore all inputs
- tick_1hz  input  1  one-cycle strobe, once per second
- btn_mode  input  1  one-cycle pulse, debounced upstream; advances set mode
- btn_inc  input  1  one-cycle pulse, debounced upstream; increments the selected field
- sec_t, sec_u  output  4 each  seconds, BCD tens/units
- min_t, min_u  output  4 each  minutes, BCD tens/units
- hr_t, hr_u  output  4 each  hours, BCD tens/units
- pm  output  1  PM flag; held 0 when H24=1
- mode  output  2  0 = RUN, 1 = SET_HR, 2 = SET_MIN
- day_wrap  output  1  one-cycle pulse on rollover to the day start

Behaviour:
- Reset (reset=0 at a clock_50MHZ edge):
  - H24=1: time 00:00:00.
  - H24=0: time 12:00:00, pm=0.
  - mode=RUN, day_wrap=0.
  - Reset wins over every other input in the same cycle.
- All outputs are registered. A field changes on the same edge that samples the causing strobe (1-cycle latency from strobe to output).
- enable=0: every register holds, tick_1hz/btn_mode/btn_inc are discarded, day_wrap=0.
- FSM: RUN -btn_mode-> SET_HR -btn_mode-> SET_MIN -btn_mode-> RUN. Only btn_mode changes state.
- RUN + tick_1hz:
  - Seconds increment 00..59.
  - 59 -> 00 carries into minutes (00..59).
  - Minute 59 -> 00 with a seconds carry carries into hours.
- Hours, H24=1: 23 -> 00.
- Hours, H24=0:
  - Sequence 12,01,02..11,12.
  - pm toggles on the 11 -> 12 transition.
  - 01..09 shown as hr_t=0.
- day_wrap:
  - H24=1: asserted for exactly one cycle on 23:59:59 -> 00:00:00.
  - H24=0: asserted on 11:59:59 PM -> 12:00:00 AM.
- Entering SET_HR clears seconds to 00.
- In SET_HR and SET_MIN:
  - tick_1hz is ignored; seconds stay at 00.
  - btn_inc increments only the selected field, with wrap (minutes 59 -> 00, hours per H24 rules, pm toggle in 12h on 11 -> 12).
  - No carry into other fields and no day_wrap.
- Leaving SET_MIN for RUN: counting resumes from xx:yy:00 on the next tick.
- Same-cycle priority:
  - btn_mode + btn_inc: mode change taken, inc discarded.
  - btn_mode + tick_1hz in RUN: mode change taken (seconds cleared), tick discarded.
  - btn_inc in RUN: ignored.
- BCD invariant: no digit ever leaves its legal range (units 0..9, sec/min tens 0..5, hr_t 0..2). The bench asserts this every cycle.

Decomposition:
- Shared package (clock_pkg):
  - mode encodings MODE_RUN/MODE_SET_HR/MODE_SET_MIN.
  - limits SEC_MAX=59, MIN_MAX=59, HR24_MAX=23, HR12_MIN=1, HR12_MAX=12.
- Sub-module bcd_mod_counter:
  - Two-digit BCD counter with a parameterised wrap pair (max value, reload value).
  - Ports: inc, clear, carry_out (combinational: inc and at max).
  - Instantiated for seconds and minutes, and for hours in 24h mode.
  - 12h hour logic and pm live in the top.
- FSM and priority logic live in the top.

Test Plan:
- Reset, then 60 ticks in RUN (H24=1) -> 00:01:00; one-cycle carry into min_u observed on the 60th tick edge.
- Preload 23:59:58 via set mode, then 2 ticks -> 23:59:59 then 00:00:00; day_wrap high exactly 1 cycle.
- H24=0 build at 11:59:59 AM, 1 tick -> 12:00:00, pm=1. At 11:59:59 PM, 1 tick -> 12:00:00, pm=0 with day_wrap.
- Set mode: time 10:20:35, btn_mode -> SET_HR with sec=00. Then:
  - 14 btn_inc -> hr 00; ticks ignored.
  - btn_mode, 45 btn_inc -> min 05.
  - btn_mode -> RUN; next tick -> 00:05:01.
- Priority: btn_mode+btn_inc same cycle -> mode advances, field unchanged. btn_mode+tick in RUN -> SET_HR, sec=00.
- enable=0 for 1000 cycles with ticks/buttons -> all outputs frozen. reset=0 asserted mid SET_MIN -> 00:00:00, RUN on the next edge.
